overlap_split: RTL and testbench
================================

# overlap_split

Analysis-side framing for the MPEG-2 AAC encoder path, the inverse of the decoder's overlap/add. It accepts a continuous stream of packed stereo PCM words and emits 50%-overlapped windows of 2×HALF_WINDOW_SIZE words. Each window is the previous half-block followed by the current half-block, tagged with the same SequencePosition code the decoder uses. It sits between the PCM input interface and the windowing/MDCT stage.

## Interface
- wordLength, 16, bits per channel sample; one bus word packs two channels, `[wordLength-1:0]` and `[2*wordLength-1:wordLength]`
- HALF_WINDOW_SIZE, 512, words per half-block; must be a power of two, ≥ 2
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- pcm_in  in  2*wordLength  packed stereo input word
- pcm_in_valid  in  1  input word present
- pcm_in_ready  out  1  block accepts input this cycle
- flush  in  1  end of stream; request the final window (see Configuration)
- pcm_out  out  2*wordLength  packed stereo output word, registered
- pcm_out_valid  out  1  output word present
- pcm_out_ready  in  1  downstream accepts output
- sequencePos  out  2  00 middle, 01 first, 10 last; constant over a window
- window_start  out  1  high with the first word of each window
- window_end  out  1  high with the last word of each window

## Operation
- Two banks of HALF_WINDOW_SIZE words, ping-pong. `cur` is being filled. `prev` holds the preceding half-block.
- `hist_valid` flag: 0 after reset, so there is no previous half-block yet.
- States:
  - IDLE → FILL unconditionally, one cycle after reset deassertion.
  - FILL: pcm_in_ready=1. Each input handshake writes `cur[cnt]`, cnt++. When the HALF-th word is accepted, go to EMIT_A with cnt=0.
  - EMIT_A: output `prev` words 0..HALF-1. If hist_valid=0, the data words are zero and sequencePos=01; otherwise sequencePos=00. After the HALF-th output handshake, go to EMIT_B.
  - EMIT_B: output `cur` words 0..HALF-1. After the HALF-th handshake, swap banks, set hist_valid=1, and go to FILL.
  - LAST: entered from FILL on flush=1 when cnt=0 and hist_valid=1. Outputs `prev` words, then HALF zero words, with sequencePos=10. After 2×HALF handshakes, set hist_valid=0 and go to FILL.
- In FILL, flush is ignored when cnt≠0 or when hist_valid=0.
- pcm_in_ready=0 in every state except FILL. There is no concurrent fill and emit.
- Output data is copied bit-exact. No arithmetic is applied to sample words.
- cnt is log2(HALF_WINDOW_SIZE)+1 bits wide and is compared against HALF_WINDOW_SIZE.

## Timing
- Reset values:
  - pcm_out=0, pcm_out_valid=0, window_start=0, window_end=0, sequencePos=00, pcm_in_ready=0
  - state=IDLE, cnt=0, hist_valid=0
  - Bank contents are not reset.
- pcm_out_valid rises on the cycle after the HALF-th input word is accepted.
- Output handshake: while pcm_out_valid=1 and pcm_out_ready=0, pcm_out, sequencePos, window_start and window_end hold stable.
- Once an output word is presented, pcm_out_valid does not drop until that word is accepted. Within a window it stays high through EMIT_A→EMIT_B with no bubble.
- Sustained rate is one word per cycle in each direction when not stalled. Each window takes 2×HALF output cycles plus HALF input cycles.
- reset=1 in any state:
  - Next cycle is IDLE, and any partial window is abandoned with no further output words.
  - hist_valid=0, so the next window is tagged first.
- If flush and pcm_in_valid are both high in FILL with cnt=0 and hist_valid=1, flush wins. The input word is not accepted (pcm_in_ready drops the next cycle).

## Configuration
- `OVERLAP_SPLIT_FLUSH_EN`:
  - Defined: the flush port and the LAST state exist as described.
  - Undefined: the flush port is still present but ignored, and the LAST state is not built. A stream ends without a trailing window, and sequencePos never takes 10.

## Structure
- Shared package `aac_pkg`: SequencePosition encoding (MIDDLE=2'b00, FIRST=2'b01, LAST=2'b10). The decoder overlap/add uses the same constants.
- Sub-module `overlap_bank`: single-port-write / single-port-read memory of HALF_WINDOW_SIZE × 2*wordLength with a registered read. It is instantiated twice; bank select is done in the parent.

## Test plan
All scenarios use HALF_WINDOW_SIZE=4, wordLength=16.
- After reset, feed words 1..4, always ready → output 0,0,0,0,1,2,3,4 with sequencePos=01. window_start is high on the first 0 and window_end is high on 4.
- Continue with 5..8 → output 1,2,3,4,5,6,7,8 with sequencePos=00.
- Hold pcm_out_ready=0 for 3 cycles mid-window → pcm_out stays stable, with no word lost or duplicated.
- After 1..8, pulse flush at cnt=0 → output 5,6,7,8,0,0,0,0 with sequencePos=10. The next input window is tagged 01.
- Assert reset during EMIT_B → output stops. Feeding 9..12 then yields 0,0,0,0,9,10,11,12 tagged 01.
- Pulse flush at cnt=2, or directly after reset → flush is ignored and normal framing continues.

Source files
------------

// File: rtl/aac_pkg.sv
// Constants shared by the AAC encoder framing and the decoder overlap/add:
// the SequencePosition tag that travels with every window.
package aac_pkg;

  typedef enum logic [1:0] {
    SEQ_MIDDLE = 2'b00,
    SEQ_FIRST  = 2'b01,
    SEQ_LAST   = 2'b10
  } seq_pos_e;

endpackage

// File: rtl/overlap_bank.sv
// One half-block of sample storage: single write port, single read port with a
// registered read that only advances on rd_en, so a stalled reader keeps its word.
module overlap_bank #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem_q[rd_addr];
    end
  end

endmodule

// File: rtl/overlap_split.sv
// Splits a packed stereo PCM stream into 50%-overlapped windows (prev half + cur half).
// Trailing LAST window on flush is built only when OVERLAP_SPLIT_FLUSH_EN is defined.
module overlap_split
  import aac_pkg::*;
#(
  parameter int wordLength       = 16,
  parameter int HALF_WINDOW_SIZE = 512
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2*wordLength-1:0] pcm_in,
  input  logic                    pcm_in_valid,
  output logic                    pcm_in_ready,
  input  logic                    flush,
  output logic [2*wordLength-1:0] pcm_out,
  output logic                    pcm_out_valid,
  input  logic                    pcm_out_ready,
  output logic [1:0]              sequencePos,
  output logic                    window_start,
  output logic                    window_end
);

  localparam int W  = 2 * wordLength;
  localparam int AW = $clog2(HALF_WINDOW_SIZE);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST_HALF = CW'(HALF_WINDOW_SIZE - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FILL   = 3'd1;
  localparam logic [2:0] ST_EMIT_A = 3'd2;
  localparam logic [2:0] ST_EMIT_B = 3'd3;
`ifdef OVERLAP_SPLIT_FLUSH_EN
  localparam logic [2:0]    ST_LAST   = 3'd4;
  localparam logic [CW-1:0] LAST_FULL = CW'(2 * HALF_WINDOW_SIZE - 1);
`endif

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          hist_q, hist_d;
  logic          cur_sel_q, cur_sel_d;
  logic          out_valid_q, out_valid_d;
  logic          out_start_q, out_start_d;
  logic          out_end_q, out_end_d;
  logic          out_zero_q, out_zero_d;
  logic          out_src_q, out_src_d;
  seq_pos_e      seq_q, seq_d;

  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data [2];
  logic          in_fire, out_fire, flush_take;

`ifdef OVERLAP_SPLIT_FLUSH_EN
  assign flush_take = (state_q == ST_FILL) && flush && (cnt_q == '0) && hist_q;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_take   = 1'b0;
`endif

  assign pcm_in_ready = (state_q == ST_FILL);
  assign in_fire      = pcm_in_ready && pcm_in_valid && !flush_take;
  assign out_fire     = out_valid_q && pcm_out_ready;
  assign cnt_inc      = cnt_q + CW'(1);

  // Bank read registers are the output stage; the word held there only
  // advances on a handshake, so a stall freezes everything downstream.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      overlap_bank #(.DEPTH(HALF_WINDOW_SIZE), .WIDTH(W)) u_bank (
        .clk    (clk),
        .wr_en  (in_fire && (cur_sel_q == 1'(gi))),
        .wr_addr(cnt_q[AW-1:0]),
        .wr_data(pcm_in),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data[gi])
      );
    end
  endgenerate

  assign pcm_out       = out_zero_q ? '0 : rd_data[out_src_q];
  assign pcm_out_valid = out_valid_q;
  assign sequencePos   = seq_q;
  assign window_start  = out_start_q;
  assign window_end    = out_end_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hist_d      = hist_q;
    cur_sel_d   = cur_sel_q;
    out_valid_d = out_valid_q;
    out_start_d = out_start_q;
    out_end_d   = out_end_q;
    out_zero_d  = out_zero_q;
    out_src_d   = out_src_q;
    seq_d       = seq_q;
    rd_en       = 1'b0;
    rd_addr     = cnt_inc[AW-1:0];
    case (state_q)
      ST_IDLE: state_d = ST_FILL;
      ST_FILL: begin
`ifdef OVERLAP_SPLIT_FLUSH_EN
        if (flush_take) begin
          state_d     = ST_LAST;
          cnt_d       = '0;
          rd_en       = 1'b1;
          rd_addr     = '0;
          out_valid_d = 1'b1;
          out_start_d = 1'b1;
          out_end_d   = 1'b0;
          out_zero_d  = 1'b0;
          out_src_d   = ~cur_sel_q;
          seq_d       = SEQ_LAST;
        end else
`endif
        if (in_fire) begin
          if (cnt_q == LAST_HALF) begin
            state_d     = ST_EMIT_A;
            cnt_d       = '0;
            rd_en       = 1'b1;
            rd_addr     = '0;
            out_valid_d = 1'b1;
            out_start_d = 1'b1;
            out_end_d   = 1'b0;
            out_zero_d  = !hist_q;
            out_src_d   = ~cur_sel_q;
            seq_d       = hist_q ? SEQ_MIDDLE : SEQ_FIRST;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_EMIT_A: begin
        if (out_fire) begin
          rd_en       = 1'b1;
          out_start_d = 1'b0;
          if (cnt_q == LAST_HALF) begin
            state_d    = ST_EMIT_B;
            cnt_d      = '0;
            rd_addr    = '0;
            out_src_d  = cur_sel_q;
            out_zero_d = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_EMIT_B: begin
        if (out_fire) begin
          if (cnt_q == LAST_HALF) begin
            state_d     = ST_FILL;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            out_end_d   = 1'b0;
            cur_sel_d   = ~cur_sel_q;
            hist_d      = 1'b1;
          end else begin
            rd_en     = 1'b1;
            cnt_d     = cnt_inc;
            out_end_d = (cnt_inc == LAST_HALF);
          end
        end
      end
`ifdef OVERLAP_SPLIT_FLUSH_EN
      ST_LAST: begin
        if (out_fire) begin
          if (cnt_q == LAST_FULL) begin
            state_d     = ST_FILL;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            out_end_d   = 1'b0;
            hist_d      = 1'b0;
          end else begin
            // Upper half of the count walks the zero padding after prev.
            rd_en       = 1'b1;
            cnt_d       = cnt_inc;
            out_start_d = 1'b0;
            out_zero_d  = cnt_inc[AW];
            out_end_d   = (cnt_inc == LAST_FULL);
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hist_q      <= 1'b0;
      cur_sel_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
      out_end_q   <= 1'b0;
      out_zero_q  <= 1'b1;
      out_src_q   <= 1'b0;
      seq_q       <= SEQ_MIDDLE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hist_q      <= hist_d;
      cur_sel_q   <= cur_sel_d;
      out_valid_q <= out_valid_d;
      out_start_q <= out_start_d;
      out_end_q   <= out_end_d;
      out_zero_q  <= out_zero_d;
      out_src_q   <= out_src_d;
      seq_q       <= seq_d;
    end
  end

endmodule

// File: tb/tb_overlap_split.sv
// Scoreboard bench for overlap_split (HALF=4): a window-level model queues expected words,
// an independent monitor pops them on every output handshake.
module tb_overlap_split;

  localparam int H = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pcm_in = '0;
  logic        pcm_in_valid = 1'b0;
  logic        pcm_in_ready;
  logic        flush = 1'b0;
  logic [31:0] pcm_out;
  logic        pcm_out_valid;
  logic        pcm_out_ready = 1'b0;
  logic [1:0]  sequencePos;
  logic        window_start;
  logic        window_end;

  overlap_split #(.wordLength(16), .HALF_WINDOW_SIZE(H)) dut (
    .clk          (clk),
    .reset        (reset),
    .pcm_in       (pcm_in),
    .pcm_in_valid (pcm_in_valid),
    .pcm_in_ready (pcm_in_ready),
    .flush        (flush),
    .pcm_out      (pcm_out),
    .pcm_out_valid(pcm_out_valid),
    .pcm_out_ready(pcm_out_ready),
    .sequencePos  (sequencePos),
    .window_start (window_start),
    .window_end   (window_end)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  seq;
    logic        s;
    logic        e;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] cur_q[$];
  logic [31:0] prev_words [H];
  bit          hist = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          ready_mode = 0;   // 0 random, 1 always ready, 2 stalled

`ifdef OVERLAP_SPLIT_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  function automatic void push_exp(logic [31:0] d, logic [1:0] seq, logic s, logic e);
    exp_t x;
    x.d = d; x.seq = seq; x.s = s; x.e = e;
    exp_q.push_back(x);
  endfunction

  // A full half-block produces one window: previous half (or zeros) then this half.
  function automatic void model_accept(logic [31:0] w);
    logic [1:0] seq;
    cur_q.push_back(w);
    if (cur_q.size() == H) begin
      seq = hist ? 2'b00 : 2'b01;
      for (int i = 0; i < H; i++) push_exp(hist ? prev_words[i] : 32'h0, seq, i == 0, 1'b0);
      for (int i = 0; i < H; i++) push_exp(cur_q[i], seq, 1'b0, i == H - 1);
      for (int i = 0; i < H; i++) prev_words[i] = cur_q[i];
      hist = 1'b1;
      cur_q.delete();
    end
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < H; i++) push_exp(prev_words[i], 2'b10, i == 0, 1'b0);
    for (int i = 0; i < H; i++) push_exp(32'h0, 2'b10, 1'b0, i == H - 1);
    hist = 1'b0;
  endfunction

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pcm_in_valid = 1'b0;
    flush = 1'b0;
    #1;
    cur_q.delete();
    exp_q.delete();
    hist = 1'b0;
    @(negedge clk);
    #1;
    check_eq("rst_out_valid", 32'(pcm_out_valid), 32'h0);
    check_eq("rst_pcm_out", pcm_out, 32'h0);
    check_eq("rst_in_ready", 32'(pcm_in_ready), 32'h0);
    check_eq("rst_seqpos", 32'(sequencePos), 32'h0);
    check_eq("rst_win_start", 32'(window_start), 32'h0);
    check_eq("rst_win_end", 32'(window_end), 32'h0);
    reset = 1'b0;
    $display("reset applied");
  endtask

  task automatic send(input logic [31:0] w);
    int  budget = 0;
    bit  acc = 1'b0;
    pcm_in = w;
    pcm_in_valid = 1'b1;
    do begin
      #1;
      acc = pcm_in_ready;
      if (acc) begin
        model_accept(w);
        $display("in  word=%h", w);
      end
      @(negedge clk);
      budget++;
    end while (!acc && budget < 500);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept within 500 cycles for %h", w);
    end
    pcm_in_valid = 1'b0;
  endtask

  task automatic pulse_flush(input bit with_valid, input logic [31:0] w);
    bit eff;
    flush = 1'b1;
    pcm_in_valid = with_valid;
    pcm_in = w;
    #1;
    eff = FLUSH_EN && pcm_in_ready && (cur_q.size() == 0) && hist;
    if (eff) model_flush();
    else if (with_valid && pcm_in_ready) model_accept(w);
    $display("flush pulse valid=%0d taken=%0d", with_valid, eff);
    @(negedge clk);
    flush = 1'b0;
    pcm_in_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int b = 0;
    while (!pcm_in_ready && b < 500) begin
      @(negedge clk);
      b++;
    end
    if (!pcm_in_ready) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: got ready=0 expected ready=1 within 500 cycles");
    end
  endtask

  // Monitor: drives pcm_out_ready, checks stall stability, pops on each handshake.
  initial begin : monitor
    bit          held = 1'b0;
    logic [31:0] snap_d;
    logic [1:0]  snap_seq;
    logic        snap_s, snap_e;
    exp_t        x;
    forever begin
      @(negedge clk);
      case (ready_mode)
        1:       pcm_out_ready = 1'b1;
        2:       pcm_out_ready = 1'b0;
        default: pcm_out_ready = ($urandom_range(0, 3) != 0);
      endcase
      #2;
      if (reset) begin
        held = 1'b0;
        continue;
      end
      if (held) begin
        checks++;
        if (!pcm_out_valid || pcm_out !== snap_d || sequencePos !== snap_seq ||
            window_start !== snap_s || window_end !== snap_e) begin
          errors++;
          $display("FAIL stall_hold: got v=%0d d=%h seq=%0d s=%0d e=%0d expected v=1 d=%h seq=%0d s=%0d e=%0d",
                   pcm_out_valid, pcm_out, sequencePos, window_start, window_end,
                   snap_d, snap_seq, snap_s, snap_e);
        end
      end
      held = 1'b0;
      if (pcm_out_valid) begin
        if (pcm_out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: got d=%h seq=%0d expected no output", pcm_out, sequencePos);
          end else begin
            x = exp_q.pop_front();
            if (pcm_out !== x.d || sequencePos !== x.seq || window_start !== x.s || window_end !== x.e) begin
              errors++;
              $display("FAIL out_word: got d=%h seq=%0d s=%0d e=%0d expected d=%h seq=%0d s=%0d e=%0d",
                       pcm_out, sequencePos, window_start, window_end, x.d, x.seq, x.s, x.e);
            end else begin
              $display("out word=%h seq=%0d start=%0d end=%0d", pcm_out, sequencePos, window_start, window_end);
            end
          end
        end else begin
          held = 1'b1;
          snap_d = pcm_out; snap_seq = sequencePos; snap_s = window_start; snap_e = window_end;
        end
      end
    end
  end

  initial begin : stimulus
    int budget;
    @(negedge clk);
    do_reset();

    // First window (FIRST tag), then a MIDDLE window stalled mid-way.
    ready_mode = 1;
    for (int w = 1; w <= 4; w++) send(32'(w));
    for (int w = 5; w <= 8; w++) send(32'(w));
    repeat (3) @(negedge clk);
    ready_mode = 2;
    repeat (3) @(negedge clk);
    ready_mode = 1;

    // Flush at cnt=0 with a competing input word; then a fresh window.
    wait_ready();
    pulse_flush(1'b1, 32'h99);
    wait_ready();
    for (int w = 21; w <= 24; w++) send(32'(w));
    wait_ready();

    // Reset during EMIT_B abandons the window; next one is FIRST again.
    do_reset();
    for (int w = 1; w <= 8; w++) send(32'(w));
    repeat (6) @(negedge clk);
    do_reset();
    for (int w = 9; w <= 12; w++) send(32'(w));
    wait_ready();

    // Flush straight after reset and at cnt=2 must not disturb framing.
    do_reset();
    pulse_flush(1'b0, 32'h0);
    send(32'h1);
    send(32'h2);
    pulse_flush(1'b1, 32'h50);
    send(32'h3);
    send(32'h4);
    wait_ready();

    // Randomized traffic with idle gaps, random back-pressure and random flushes.
    ready_mode = 0;
    for (int k = 0; k < 60; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 9) == 0) pulse_flush(1'($urandom_range(0, 1)), $urandom);
      else send($urandom);
    end

    budget = 0;
    while (exp_q.size() != 0 && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d words pending expected 0", exp_q.size());
    end
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
